cd_tx_bytes: RTL and testbench
==============================

Name: cd_tx_bytes

Overview:
- Transmit-side byte engine for CDBUS.
- Reads one frame from the pp_ram TX buffer and presents it byte-by-byte to the serializer (tx_ser) over a valid/ack handshake.
- Frame order: src_addr, dst_addr, data_len, [data], crc_l, crc_h. The CRC is computed here unless user_crc is set.
- Sits between cd_csr/pp_ram and tx_ser. Releases the buffer when the frame completes.

Parameters:
- none

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tx_pending  in  1  level; a complete frame is waiting in the TX buffer (cd_csr)
- user_crc  in  1  level; the frame already holds its CRC bytes, send them verbatim
- abort  in  1  pulse; drop the current frame immediately
- tx_done  out  1  pulse; frame fully handed to the serializer
- ram_rd_addr  out  8  TX buffer read address
- ram_rd_en  out  1  read strobe; ram_rd_byte is valid on the cycle after the strobe
- ram_rd_byte  in  8  TX buffer read data
- ram_rd_done  out  1  pulse; buffer released to cd_csr, asserted together with tx_done
- ser_data  out  8  byte to the serializer
- ser_data_valid  out  1  level; ser_data is valid
- ser_data_last  out  1  level while ser_data_valid; the current byte is crc_h (the final byte)
- ser_data_ack  in  1  pulse; serializer took ser_data

Behaviour:
- Reset values: all outputs 0; state IDLE; byte_cnt 0; data_len 0; crc 16'hffff.
- CRC: CRC-16/MODBUS (reflected poly 0xA001, init 0xFFFF). Update is 8 bits per cycle, applied when a RAM byte is latched into ser_data.
- CRC output order: crc_l = crc[7:0] is sent first, then crc_h = crc[15:8].
- Counters: byte_cnt is 9 bits; ram_rd_addr = byte_cnt[7:0].
- Frame length: total = data_len + 5.
  - user_crc=0: RAM supplies data_len + 3 bytes, then the 2 generated CRC bytes follow.
  - user_crc=1: all data_len + 5 bytes come from RAM.
- Length clamp (buffer is 256 bytes): data_len is clamped to 253 when user_crc=0 and to 251 when user_crc=1. The clamp is applied when byte 2 is latched.
- State machine:
  - IDLE:
    - crc <= 16'hffff; byte_cnt <= 0; data_len <= 0.
    - If tx_pending and !abort: pulse ram_rd_en with addr 0, then go to FETCH.
  - FETCH (one-cycle RAM latency):
    - ser_data <= ram_rd_byte; ser_data_valid <= 1; update crc.
    - If byte_cnt == 2, data_len <= clamp(ram_rd_byte).
    - Go to SEND.
  - SEND, waiting for ser_data_ack. On ack:
    - ser_data_valid <= 0; byte_cnt++.
    - If more RAM bytes remain: ram_rd_en pulse with the next addr, go to FETCH.
    - Else if user_crc=1: go to DONE.
    - Else: ser_data <= crc[7:0], valid <= 1, go to CRC_L.
  - CRC_L: on ack, ser_data <= crc[15:8], valid <= 1, ser_data_last <= 1, go to CRC_H.
  - CRC_H: on ack, valid <= 0, last <= 0, go to DONE.
  - DONE: pulse tx_done and ram_rd_done for one cycle, go to IDLE.
- ser_data_last with user_crc=1: asserted on the byte fetched at index data_len + 4.
- Handshake timing: ser_data_valid drops the cycle after an ack. Each byte costs at least 2 cycles (read + present). Acks received while valid=0 are ignored.
- Start latency: tx_pending high → ser_data_valid high 2 cycles later.
- Data stability: ser_data is stable while valid is high.
- abort, any state: next cycle state is IDLE.
  - ser_data_valid and ser_data_last are cleared.
  - No tx_done and no ram_rd_done; the buffer is retained.
  - abort overrides a simultaneous ack or a DONE transition.
- tx_pending:
  - Sampled only in IDLE; changes mid-frame are ignored.
  - If tx_pending stays high after DONE, the next frame starts from IDLE (one idle cycle minimum).
- Asynchronous reset mid-frame: all state is cleared immediately, with no pulses.

Test Plan:
- RAM = 01 02 00, user_crc=0, immediate acks → serializer gets 01 02 00 then the two MODBUS CRC bytes of {01,02,00} (low byte first); last is high on the final byte; tx_done and ram_rd_done pulse once, together.
- RAM = 01 02 03 AA BB CC, user_crc=0, ack delayed 10 cycles per byte → 8 bytes total in order; ser_data stable while valid; CRC of the 6 bytes appended.
- user_crc=1, RAM = 05 00 01 7E 12 34 → exactly 6 bytes sent verbatim, last on 34; no generated bytes.
- data_len=0xFF, user_crc=0 → clamped to 253; 258 bytes total; ram_rd_addr reaches 255 and does not wrap.
- abort asserted during the 2nd byte's SEND → valid drops the next cycle; no tx_done or ram_rd_done; with tx_pending still high, the frame restarts from addr 0 and completes correctly.

Source files
------------

// File: rtl/cd_tx_bytes.sv
// CDBUS transmit byte engine: fetches one frame from the TX buffer and hands it
// to the serializer byte by byte, appending a CRC-16/MODBUS unless user_crc is set.
module cd_tx_bytes (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_pending,
  input  logic       user_crc,
  input  logic       abort,
  output logic       tx_done,
  output logic [7:0] ram_rd_addr,
  output logic       ram_rd_en,
  input  logic [7:0] ram_rd_byte,
  output logic       ram_rd_done,
  output logic [7:0] ser_data,
  output logic       ser_data_valid,
  output logic       ser_data_last,
  input  logic       ser_data_ack
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_CRC_L = 3'd3,
    S_CRC_H = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {8'h00, din};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // The 256-byte buffer must hold header, payload and both CRC bytes.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic ucrc);
    logic [7:0] lim;
    lim = ucrc ? 8'd251 : 8'd253;
    return (len > lim) ? lim : len;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [8:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [7:0]  r_data_len, w_data_len_nxt;
  logic [15:0] r_crc, w_crc_nxt;
  logic [7:0]  r_ser_data, w_ser_data_nxt;
  logic        r_ser_valid, w_ser_valid_nxt;
  logic        r_ser_last, w_ser_last_nxt;
  logic        w_rd_en;
  logic        w_done;
  logic [8:0]  w_cnt_inc;
  logic [8:0]  w_ram_total;
  logic [8:0]  w_last_idx;

  assign w_cnt_inc   = r_byte_cnt + 9'd1;
  assign w_ram_total = {1'b0, r_data_len} + (user_crc ? 9'd5 : 9'd3);
  assign w_last_idx  = {1'b0, r_data_len} + 9'd4;

  assign ram_rd_addr    = w_byte_cnt_nxt[7:0];
  assign ram_rd_en      = w_rd_en;
  assign tx_done        = w_done;
  assign ram_rd_done    = w_done;
  assign ser_data       = r_ser_data;
  assign ser_data_valid = r_ser_valid;
  assign ser_data_last  = r_ser_last;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= 9'd0;
      r_data_len  <= 8'd0;
      r_crc       <= 16'hFFFF;
      r_ser_data  <= 8'd0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_data_len  <= w_data_len_nxt;
      r_crc       <= w_crc_nxt;
      r_ser_data  <= w_ser_data_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_ser_last  <= w_ser_last_nxt;
    end
  end

  // Next-state, datapath updates and RAM/handshake strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_data_len_nxt  = r_data_len;
    w_crc_nxt       = r_crc;
    w_ser_data_nxt  = r_ser_data;
    w_ser_valid_nxt = r_ser_valid;
    w_ser_last_nxt  = r_ser_last;
    w_rd_en         = 1'b0;
    w_done          = 1'b0;
    if (abort) begin
      // Abort wins over any ack or completion; the buffer stays owned by us.
      w_state_nxt     = S_IDLE;
      w_ser_valid_nxt = 1'b0;
      w_ser_last_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_crc_nxt      = 16'hFFFF;
          w_byte_cnt_nxt = 9'd0;
          w_data_len_nxt = 8'd0;
          if (tx_pending) begin
            w_rd_en     = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_FETCH: begin
          w_ser_data_nxt  = ram_rd_byte;
          w_ser_valid_nxt = 1'b1;
          w_crc_nxt       = crc16_upd(r_crc, ram_rd_byte);
          if (r_byte_cnt == 9'd2) begin
            w_data_len_nxt = clamp_len(ram_rd_byte, user_crc);
          end else begin
            w_data_len_nxt = r_data_len;
          end
          if (user_crc && (r_byte_cnt == w_last_idx)) begin
            w_ser_last_nxt = 1'b1;
          end else begin
            w_ser_last_nxt = 1'b0;
          end
          w_state_nxt = S_SEND;
        end
        S_SEND: begin
          if (ser_data_ack) begin
            w_ser_valid_nxt = 1'b0;
            w_byte_cnt_nxt  = w_cnt_inc;
            if (w_cnt_inc < w_ram_total) begin
              w_rd_en     = 1'b1;
              w_state_nxt = S_FETCH;
            end else if (user_crc) begin
              w_ser_last_nxt = 1'b0;
              w_state_nxt    = S_DONE;
            end else begin
              w_ser_data_nxt  = r_crc[7:0];
              w_ser_valid_nxt = 1'b1;
              w_state_nxt     = S_CRC_L;
            end
          end else begin
            w_state_nxt = S_SEND;
          end
        end
        S_CRC_L: begin
          if (ser_data_ack) begin
            w_ser_data_nxt  = r_crc[15:8];
            w_ser_valid_nxt = 1'b1;
            w_ser_last_nxt  = 1'b1;
            w_state_nxt     = S_CRC_H;
          end else begin
            w_state_nxt = S_CRC_L;
          end
        end
        S_CRC_H: begin
          if (ser_data_ack) begin
            w_ser_valid_nxt = 1'b0;
            w_ser_last_nxt  = 1'b0;
            w_state_nxt     = S_DONE;
          end else begin
            w_state_nxt = S_CRC_H;
          end
        end
        S_DONE: begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_ser_valid_nxt = 1'b0;
          w_ser_last_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cd_tx_bytes.sv
// Scoreboard bench for cd_tx_bytes: expected {last,data} bytes are queued at
// stimulus time and popped by an independent monitor on every accepted byte.
module tb_cd_tx_bytes;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_pending;
  logic       user_crc;
  logic       abort;
  logic       tx_done;
  logic [7:0] ram_rd_addr;
  logic       ram_rd_en;
  logic [7:0] ram_rd_byte;
  logic       ram_rd_done;
  logic [7:0] ser_data;
  logic       ser_data_valid;
  logic       ser_data_last;
  logic       ser_data_ack;

  logic [7:0] mem [256];
  logic [8:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int rd_cnt = 0;
  int max_addr = 0;
  int ack_delay = 0;

  cd_tx_bytes dut (
    .clk(clk), .reset_n(reset_n), .tx_pending(tx_pending), .user_crc(user_crc),
    .abort(abort), .tx_done(tx_done), .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en),
    .ram_rd_byte(ram_rd_byte), .ram_rd_done(ram_rd_done), .ser_data(ser_data),
    .ser_data_valid(ser_data_valid), .ser_data_last(ser_data_last), .ser_data_ack(ser_data_ack)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffer: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_byte <= mem[ram_rd_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit-serial reflected CRC-16/MODBUS over mem[0..n-1].
  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ mem[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic push_ram(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b0, mem[k]});
  endtask

  task automatic push_crc(input int n);
    logic [15:0] c;
    c = ref_crc(n);
    exp_q.push_back({1'b0, c[7:0]});
    exp_q.push_back({1'b1, c[15:8]});
  endtask

  // Serializer model: acks each presented byte after ack_delay cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    ser_data_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ser_data_ack = 1'b0;
      if (ser_data_valid) begin
        if (wait_cnt >= ack_delay) begin
          ser_data_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: scoreboard pops, data stability, done pairing, read tracking.
  initial begin
    logic       prev_valid, prev_ack;
    logic [7:0] prev_data;
    logic [8:0] e;
    prev_valid = 1'b0;
    prev_ack   = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (ram_rd_en) begin
          rd_cnt++;
          if (int'(ram_rd_addr) > max_addr) max_addr = int'(ram_rd_addr);
        end
        if (tx_done || ram_rd_done) begin
          chk("done_pair", {31'd0, ram_rd_done}, {31'd0, tx_done});
          if (tx_done) done_cnt++;
        end
        if (prev_valid && ser_data_valid && !prev_ack)
          chk("data_stable", {24'd0, ser_data}, {24'd0, prev_data});
        if (ser_data_valid && ser_data_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", ser_data);
          end else begin
            e = exp_q.pop_front();
            chk("byte", {23'd0, ser_data_last, ser_data}, {23'd0, e});
          end
          acc_cnt++;
        end
      end
      prev_valid = ser_data_valid;
      prev_ack   = ser_data_ack;
      prev_data  = ser_data;
    end
  end

  task automatic wait_done(input int d0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    tx_pending = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no tx_done expected one");
    end
    @(negedge clk);
    chk("done_count", done_cnt, d0 + 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic send_frame(input bit chk_lat);
    int d0;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    tx_pending = 1'b1;
    if (chk_lat) begin
      @(posedge clk);
      #1;
      chk("latency_1", {31'd0, ser_data_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("latency_2", {31'd0, ser_data_valid}, 32'd1);
    end
    wait_done(d0);
  endtask

  initial begin
    int d0, base;
    bit ok;
    reset_n = 1'b0;
    tx_pending = 1'b0;
    user_crc = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, ser_data_valid}, 32'd0);
    chk("rst_last", {31'd0, ser_data_last}, 32'd0);
    chk("rst_data", {24'd0, ser_data}, 32'd0);
    chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
    chk("rst_rd_done", {31'd0, ram_rd_done}, 32'd0);
    chk("rst_rd_en", {31'd0, ram_rd_en}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Minimal frame, immediate acks, hand-computed CRC 0x6021.
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h00;
    ack_delay = 0;
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h21});
    exp_q.push_back({1'b1, 8'h60});
    send_frame(1'b1);

    // Three payload bytes with slow acks.
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    mem[3] = 8'hAA; mem[4] = 8'hBB; mem[5] = 8'hCC;
    ack_delay = 10;
    push_ram(6);
    push_crc(6);
    send_frame(1'b0);

    // User-supplied CRC: six bytes verbatim, last on the sixth.
    mem[0] = 8'h05; mem[1] = 8'h00; mem[2] = 8'h01;
    mem[3] = 8'h7E; mem[4] = 8'h12; mem[5] = 8'h34;
    user_crc = 1'b1;
    ack_delay = 1;
    push_ram(5);
    exp_q.push_back({1'b1, 8'h34});
    send_frame(1'b0);
    user_crc = 1'b0;

    // Oversized length clamps to 253: 256 RAM bytes plus 2 CRC bytes.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[2] = 8'hFF;
    ack_delay = 0;
    rd_cnt = 0;
    max_addr = 0;
    push_ram(256);
    push_crc(256);
    send_frame(1'b0);
    chk("clamp_reads", rd_cnt, 256);
    chk("clamp_max_addr", max_addr, 255);

    // Abort during the second byte, then automatic restart from address 0.
    mem[0] = 8'h0A; mem[1] = 8'h0B; mem[2] = 8'h02; mem[3] = 8'hC1; mem[4] = 8'hC2;
    ack_delay = 10;
    exp_q.push_back({1'b0, 8'h0A});
    push_ram(5);
    push_crc(5);
    d0 = done_cnt;
    base = acc_cnt;
    @(posedge clk);
    #1;
    tx_pending = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (acc_cnt == base + 1) ok = 1'b1;
    end
    chk("abort_first_byte", {31'd0, ok}, 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ser_data_valid) ok = 1'b1;
    end
    chk("abort_second_valid", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_valid_drop", {31'd0, ser_data_valid}, 32'd0);
    chk("abort_last_drop", {31'd0, ser_data_last}, 32'd0);
    chk("abort_no_done", done_cnt, d0);
    wait_done(d0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
